// File: rtl/accel_result_reader_pkg.sv
// rtl/accel_result_reader_pkg.sv - shared widths, limits and state encoding for the result reader
package accel_result_reader_pkg;

  localparam int ADDR_W         = 12;
  localparam int DATA_W         = 16;
  localparam int CNT_W          = 6;
  localparam int TIMEOUT_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    DRAIN,
    FIN
  } state_t;

  // A zero-length request still reads back one word.
  function automatic logic [CNT_W-1:0] norm_words(input logic [CNT_W-1:0] n);
    return (n == '0) ? CNT_W'(1) : n;
  endfunction

endpackage

// File: rtl/accel_result_reader_skid_fifo2.sv
// rtl/accel_result_reader_skid_fifo2.sv - two-entry skid FIFO carrying result data plus last flag
module skid_fifo2
  import accel_result_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        level
);

  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign rd_valid = (count != 2'd0);
  assign pop      = rd_valid && rd_ready;
  // A write into a full FIFO is only allowed when the head leaves in the same cycle.
  assign push     = wr_en && ((count != 2'd2) || pop);
  assign rd_data  = data_q[rd_ptr];
  assign rd_last  = rd_valid && last_q[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr] <= wr_data;
        last_q[wr_ptr] <= wr_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accel_result_reader.sv
// rtl/accel_result_reader.sv - launches one accelerator job and streams its output SRAM words back
module accel_result_reader
  import accel_result_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              err_timeout
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] words;
  logic [CNT_W-1:0] last_addr;
  logic [CNT_W-1:0] rd_addr;
  logic             all_issued;
  logic             inflight;
  logic             inflight_last;
  logic [3:0]       wait_cnt;
  logic [1:0]       fifo_level;
  logic [2:0]       occupancy;
  logic             pop;
  logic             issue;
  logic             timeout_hit;

  assign last_addr             = words - CNT_W'(1);
  assign pop                   = out_valid && out_ready;
  // Words that will still be held after this cycle's departure, counting the read in flight.
  assign occupancy             = {1'b0, fifo_level} - {2'b00, pop} + {2'b00, inflight};
  assign dut_sram_read_address = {{(ADDR_W-CNT_W){1'b0}}, rd_addr};

  always_comb begin
    state_next  = state;
    dut_run     = 1'b0;
    done        = 1'b0;
    issue       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LAUNCH;
      end
      LAUNCH: begin
        dut_run    = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (dut_busy) begin
          state_next = WAIT_LO;
        end else if (wait_cnt == 4'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_next  = FIN;
        end
      end
      WAIT_LO: begin
        if (!dut_busy) state_next = DRAIN;
      end
      DRAIN: begin
        issue = !all_issued && (occupancy <= 3'd1);
        if (pop && out_last) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      words         <= CNT_W'(1);
      rd_addr       <= '0;
      all_issued    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wait_cnt      <= 4'd0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= issue;
      inflight_last <= issue && (rd_addr == last_addr);
      wait_cnt      <= (state == WAIT_HI) ? wait_cnt + 4'd1 : 4'd0;
      if (state == IDLE && start) begin
        words       <= norm_words(num_words);
        err_timeout <= 1'b0;
      end
      if (timeout_hit) err_timeout <= 1'b1;
      // The address parks on the final word rather than wrapping.
      if (state != DRAIN) begin
        rd_addr    <= '0;
        all_issued <= 1'b0;
      end else if (issue) begin
        if (rd_addr == last_addr) all_issued <= 1'b1;
        else                      rd_addr    <= rd_addr + CNT_W'(1);
      end
    end
  end

  skid_fifo2 u_skid (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (inflight),
    .wr_data  (sram_dut_read_data),
    .wr_last  (inflight_last),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_last  (out_last),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_accel_result_reader.sv
// tb/tb_accel_result_reader.sv - directed self-checking bench for accel_result_reader
module tb_accel_result_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  num_words;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] addr;
  logic [15:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        done;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  accel_result_reader dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .num_words             (num_words),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .dut_sram_read_address (addr),
    .sram_dut_read_data    (rdata),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_last              (out_last),
    .done                  (done),
    .err_timeout           (err_timeout)
  );

  function automatic logic [15:0] word_of(input logic [11:0] a);
    return 16'h5A00 ^ {a[5:0], a[5:0], 4'h3};
  endfunction

  // Output SRAM: one-cycle read latency.
  always @(posedge clk) rdata <= word_of(addr);

  // Accelerator: busy for busy_len cycles starting the cycle after dut_run; busy_len=0 never rises.
  int busy_len  = 20;
  int busy_left = 0;
  always @(posedge clk) begin
    if (reset)              busy_left <= 0;
    else if (dut_run)       busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign dut_busy = (busy_left > 0);

  logic [15:0] got_data[$];
  logic        got_last[$];
  int          cyc = 0;
  int          run_pulses, done_pulses, run_cyc, done_cyc, last_cyc, first_valid_cyc, max_addr;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        assert (out_valid === 1'b1 && out_data === prev_data) else begin
          fails++;
          $error("FAIL stall_hold: observed valid=%b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last) last_cyc = cyc;
      end
      if (dut_run) begin run_pulses++; run_cyc = cyc; end
      if (done)    begin done_pulses++; done_cyc = cyc; end
      if (int'(addr) > max_addr) max_addr = int'(addr);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input logic [5:0] n);
    got_data.delete();
    got_last.delete();
    run_pulses = 0; done_pulses = 0; run_cyc = -1; done_cyc = -1;
    last_cyc = -1; first_valid_cyc = -1; max_addr = 0;
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready toggles 1010...; 2: ready low for 5 cycles after 3 words.
  task automatic wait_done(input int mode, input bit start_on_done, input int budget);
    int  low  = 0;
    bit  fire = 0;
    for (int i = 0; i < budget; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (i % 2 == 0);
        default: begin
          if (got_data.size() >= 3 && low < 5) begin out_ready = 1'b0; low++; end
          else out_ready = 1'b1;
        end
      endcase
      if (fire) start = 1'b1;
      sample();
      if (done_pulses > 0) return;
      fire = start_on_done && got_last.size() > 0 && got_last[got_last.size()-1];
      tick();
    end
    chk("done_wait_expired", 0, 1);
  endtask

  task automatic verify_words(input int n);
    chk("word_count", got_data.size(), n);
    for (int k = 0; k < got_data.size() && k < n; k++) begin
      chk($sformatf("data[%0d]", k), got_data[k], word_of(12'(k)));
      chk($sformatf("last[%0d]", k), got_last[k], (k == n - 1));
    end
    chk("run_pulses", run_pulses, 1);
    chk("done_pulses", done_pulses, 1);
    chk("done_after_last", done_cyc, last_cyc + 1);
    chk("max_addr", max_addr, n - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0; out_ready = 1'b1;
    repeat (3) tick();
    sample();
    chk("rst_dut_run", dut_run, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_addr", addr, 0);
    chk("rst_out_data", out_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic job, full throughput.
    busy_len = 20;
    start_job(6'd14);
    wait_done(0, 0, 200);
    tick();
    verify_words(14);
    chk("first_valid_latency", first_valid_cyc - run_cyc, 24);
    chk("one_word_per_cycle", last_cyc - first_valid_cyc, 13);

    // Back-pressure patterns.
    busy_len = 3;
    start_job(6'd9);
    wait_done(1, 0, 200);
    tick();
    verify_words(9);

    start_job(6'd12);
    wait_done(2, 0, 200);
    tick();
    verify_words(12);

    // Accelerator never goes busy.
    busy_len = 0;
    start_job(6'd5);
    wait_done(0, 0, 100);
    chk("timeout_err_set", err_timeout, 1);
    chk("timeout_done_delay", done_cyc - run_cyc, 9);
    chk("timeout_no_words", got_data.size(), 0);
    chk("timeout_no_reads", max_addr, 0);
    repeat (4) tick();
    sample();
    chk("timeout_err_sticky", err_timeout, 1);
    tick();
    busy_len = 20;
    start_job(6'd3);
    sample();
    chk("timeout_err_cleared", err_timeout, 0);
    wait_done(0, 0, 200);
    tick();
    verify_words(3);

    // Single-word jobs.
    busy_len = 2;
    start_job(6'd1);
    wait_done(0, 0, 100);
    tick();
    verify_words(1);
    start_job(6'd0);
    wait_done(0, 0, 100);
    tick();
    verify_words(1);

    // Reset three cycles into DRAIN.
    busy_len = 4;
    start_job(6'd20);
    for (int i = 0; i < 60 && first_valid_cyc < 0; i++) begin
      sample();
      if (first_valid_cyc < 0) tick();
    end
    chk("drain_reached", (first_valid_cyc >= 0), 1);
    tick();
    reset = 1'b1;
    tick();
    sample();
    chk("mid_rst_dut_run", dut_run, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err_timeout", err_timeout, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    tick();
    reset = 1'b0;
    sample();
    chk("post_rst_valid_0", out_valid, 0);
    tick();
    sample();
    chk("post_rst_valid_1", out_valid, 0);
    tick();
    start_job(6'd10);
    wait_done(0, 0, 200);
    tick();
    verify_words(10);

    // Start during WAIT_LO and on the done cycle must be ignored.
    busy_len = 10;
    start_job(6'd4);
    for (int i = 0; i < 20 && run_pulses == 0; i++) begin
      sample();
      if (run_pulses == 0) tick();
    end
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, 1, 200);
    chk("start_on_done_driven", start, 1);
    tick();
    start = 1'b0;
    repeat (15) tick();
    verify_words(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accel_result_reader.md
ACCEL_RESULT_READER -- requirements
Module: accel_result_reader

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all logic.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, host request to run one accelerator job and read back results.
REQ-004 SHALL have port num_words, input, 6, count of output words to read back (1..63), sampled on accepted start.
REQ-005 SHALL have port dut_run, output, 1, one-cycle launch pulse to the accelerator.
REQ-006 SHALL have port dut_busy, input, 1, accelerator busy flag.
REQ-007 SHALL have port dut_sram_read_address, output, 12, output-SRAM read address.
REQ-008 SHALL have port sram_dut_read_data, input, 16, output-SRAM read data, valid exactly 1 cycle after the address.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 16) and out_last (output, 1), forming the result stream.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the job completes.
REQ-011 SHALL have port err_timeout, output, 1, sticky error flag, cleared on the next accepted start.

Function
REQ-012 SHALL implement states IDLE, LAUNCH, WAIT_HI, WAIT_LO, DRAIN and FIN.
REQ-013 IDLE: start=1 SHALL latch num_words and move to LAUNCH; start SHALL be ignored in every other state.
REQ-014 LAUNCH: SHALL assert dut_run for exactly one cycle, then go to WAIT_HI.
REQ-015 WAIT_HI: dut_busy=1 SHALL move to WAIT_LO; if dut_busy is not seen within 8 cycles of dut_run, SHALL set err_timeout, pulse done and return to IDLE.
REQ-016 WAIT_LO: SHALL wait for dut_busy=0 with no timeout, then go to DRAIN with read address 0.
REQ-017 DRAIN: SHALL issue read address k=0..num_words-1 in order; an address SHALL be issued only if at most 1 word is already in the skid buffer plus in flight.
REQ-018 SHALL capture returned data into a 2-entry FIFO skid buffer; the buffer SHALL never overflow under any out_ready pattern.
REQ-019 out_valid SHALL equal "buffer non-empty"; a word SHALL transfer on out_valid&out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 out_last SHALL be 1 only with the word at index num_words-1.
REQ-021 With out_ready held at 1, SHALL sustain 1 word/cycle, and the first out_valid SHALL appear 2 cycles after DRAIN entry.
REQ-022 After the last word transfers, SHALL enter FIN, pulse done for 1 cycle, then return to IDLE.
REQ-023 num_words=0 SHALL be treated as 1.
REQ-024 dut_sram_read_address[11:6] SHALL be 0.
REQ-025 The address counter SHALL not wrap past num_words-1.
REQ-026 A start that coincides with done SHALL be ignored.

Reset
REQ-027 Reset SHALL force state=IDLE and drive dut_run=0, out_valid=0, out_last=0, done=0, err_timeout=0 and dut_sram_read_address=0.
REQ-028 Reset SHALL empty the skid buffer.
REQ-029 Reset asserted mid-DRAIN SHALL discard the in-flight read, with no out_valid in the cycle after reset deasserts.
REQ-030 out_data reset value SHALL be 0.

Structure
REQ-031 The state encoding, the timeout limit (8), the address width (12) and the data width (16) SHALL live in the shared accelerator package.
REQ-032 The 2-entry skid FIFO SHALL be one sub-module, named skid_fifo2, with 16-bit data plus a last bit.

Verification
REQ-033 Directed test: start with num_words=14, out_ready=1, and a busy model that is high for 20 cycles -> one dut_run pulse, reads of addresses 0..13, 14 words in order, out_last on word 13, done 1 cycle after that word.
REQ-034 Directed test: out_ready toggling 1010…, or held low for 5 cycles mid-stream -> no lost or duplicated words, and out_data stable while stalled.
REQ-035 Directed test: busy model that never rises -> err_timeout=1 and a done pulse 9 cycles after dut_run, no reads issued; the next start clears err_timeout.
REQ-036 Directed test: num_words=1 and num_words=0 -> a single word with out_last=1.
REQ-037 Directed test: reset asserted 3 cycles into DRAIN -> all outputs at reset values, and a following job with num_words=10 is read back correctly from address 0.
REQ-038 Directed test: start pulsed during WAIT_LO and on the done cycle -> ignored, no second dut_run.
